dot_product_accumulator: RTL and testbench

Downstream stage of the row/column fetcher. It consumes the four multiplier products issued per beat and reduces them through a registered adder tree. It accumulates `MATRIX_A_COLUMNS/4` beats into one element of C and writes each finished element into the Matrix C memory in row-major order. It pulses `done` after the last element of C is written.

---
 rtl/dot_product_accumulator.sv | 187 ++++++++++++++++++
 tb/tb_dot_product_accumulator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Reduces four products per beat through a registered adder tree, accumulates
// MATRIX_A_COLUMNS/4 beats per C element and writes C row-major. Optional macro: DPA_SATURATE_EN.
module dot_product_accumulator #(
    parameter int MATRIX_A_ROWS      = 8,
    parameter int MATRIX_A_COLUMNS   = 8,
    parameter int MATRIX_B_COLUMNS   = 8,
    parameter int MATRIX_C_MEM_DEPTH = 64,
    parameter int MATRIX_MEM_WIDTH   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  prod_valid,
    output logic                                  prod_ready,
    input  logic [MATRIX_MEM_WIDTH-1:0]           mult_1_out,
    input  logic [MATRIX_MEM_WIDTH-1:0]           mult_2_out,
    input  logic [MATRIX_MEM_WIDTH-1:0]           mult_3_out,
    input  logic [MATRIX_MEM_WIDTH-1:0]           mult_4_out,
    output logic                                  wr_en,
    output logic [$clog2(MATRIX_C_MEM_DEPTH)-1:0] wr_address_c,
    output logic [MATRIX_MEM_WIDTH-1:0]           wr_data_c,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  protocol_err,
    output logic                                  overflow
);

    // state | meaning
    // IDLE  | waiting for start, no beats accepted
    // RUN   | accepting beats, prod_ready high
    // FLUSH | last beat taken, draining the adder pipeline until done

    localparam int W     = MATRIX_MEM_WIDTH;
    localparam int AW    = $clog2(MATRIX_C_MEM_DEPTH);
    localparam int BEATS = MATRIX_A_COLUMNS / 4;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ELEMS = MATRIX_A_ROWS * MATRIX_B_COLUMNS;
    localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [EW-1:0] LAST_ELEM = EW'(ELEMS - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ELEMS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state, state_next;

    // Returns {saturated, sum}; the flag is only ever set in the saturating build.
    function automatic logic [W:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] sum;
        logic         ovf;
        sum = a + b;
        ovf = 1'b0;
`ifdef DPA_SATURATE_EN
        if ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) begin
            ovf = 1'b1;
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
        return {ovf, sum};
    endfunction

    logic [BW-1:0] beat_cnt;
    logic [EW-1:0] elem_cnt;
    logic [AW-1:0] addr_cnt;

    logic          v1, last_e1, last_m1;
    logic [W-1:0]  s12, s34;
    logic          v2, last_e2, last_m2;
    logic [W-1:0]  t;
    logic [W-1:0]  acc;

    logic [W-1:0]  s12_sum, s34_sum, t_sum, acc_sum;
    logic          s12_ovf, s34_ovf, t_ovf, acc_ovf;
    logic          xfer, accept_start, last_beat, ovf_event;

    assign {s12_ovf, s12_sum} = add_w(mult_1_out, mult_2_out);
    assign {s34_ovf, s34_sum} = add_w(mult_3_out, mult_4_out);
    assign {t_ovf, t_sum}     = add_w(s12, s34);
    assign {acc_ovf, acc_sum} = add_w(acc, t);

    assign xfer         = prod_valid & prod_ready;
    assign accept_start = start & (state == IDLE);
    assign last_beat    = (beat_cnt == LAST_BEAT);
    assign ovf_event    = (xfer & (s12_ovf | s34_ovf)) | (v1 & t_ovf) | (v2 & acc_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        prod_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                prod_ready = 1'b1;
                if (xfer && last_beat && (elem_cnt == LAST_ELEM)) state_next = FLUSH;
            end
            FLUSH: begin
                // done is registered with the final write, so the pipeline is empty here
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            elem_cnt     <= '0;
            addr_cnt     <= '0;
            v1           <= 1'b0;
            last_e1      <= 1'b0;
            last_m1      <= 1'b0;
            s12          <= '0;
            s34          <= '0;
            v2           <= 1'b0;
            last_e2      <= 1'b0;
            last_m2      <= 1'b0;
            t            <= '0;
            acc          <= '0;
            wr_en        <= 1'b0;
            wr_address_c <= '0;
            wr_data_c    <= '0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (accept_start) begin
                beat_cnt     <= '0;
                elem_cnt     <= '0;
                addr_cnt     <= '0;
                acc          <= '0;
                protocol_err <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                if (prod_valid && !prod_ready) protocol_err <= 1'b1;
                if (ovf_event) overflow <= 1'b1;
            end

            v1 <= xfer;
            if (xfer) begin
                s12      <= s12_sum;
                s34      <= s34_sum;
                last_e1  <= last_beat;
                last_m1  <= last_beat && (elem_cnt == LAST_ELEM);
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                if (last_beat) begin
                    elem_cnt <= (elem_cnt == LAST_ELEM) ? '0 : elem_cnt + EW'(1);
                end
            end

            v2 <= v1;
            if (v1) begin
                t       <= t_sum;
                last_e2 <= last_e1;
                last_m2 <= last_m1;
            end

            if (v2) begin
                if (last_e2) begin
                    wr_en        <= 1'b1;
                    wr_data_c    <= acc_sum;
                    wr_address_c <= addr_cnt;
                    addr_cnt     <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + AW'(1);
                    acc          <= '0;
                    done         <= last_m2;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: random products and gaps against
// an arithmetic reference of each C element.
module tb_dot_product_accumulator;

    localparam int ROWS  = 8;
    localparam int ACOLS = 8;
    localparam int BCOLS = 8;
    localparam int DEPTH = 64;
    localparam int W     = 32;
    localparam int BEATS = ACOLS / 4;
    localparam int ELEMS = ROWS * BCOLS;
    localparam int TOTAL = ELEMS * BEATS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [W-1:0]  m1 = '0, m2 = '0, m3 = '0, m4 = '0;
    logic          wr_en;
    logic [5:0]    wr_address_c;
    logic [W-1:0]  wr_data_c;
    logic          busy, done, protocol_err, overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [W-1:0] pr [TOTAL][4];
    int           xfer_cyc [TOTAL];
    logic [5:0]   w_addr_q [$];
    logic [W-1:0] w_data_q [$];
    bit           w_done_q [$];
    int           w_cyc_q  [$];
    bit           model_ovf;

    dot_product_accumulator #(
        .MATRIX_A_ROWS(ROWS), .MATRIX_A_COLUMNS(ACOLS), .MATRIX_B_COLUMNS(BCOLS),
        .MATRIX_C_MEM_DEPTH(DEPTH), .MATRIX_MEM_WIDTH(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .mult_1_out(m1), .mult_2_out(m2), .mult_3_out(m3),
        .mult_4_out(m4), .wr_en(wr_en), .wr_address_c(wr_address_c), .wr_data_c(wr_data_c),
        .busy(busy), .done(done), .protocol_err(protocol_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            w_addr_q.push_back(wr_address_c);
            w_data_q.push_back(wr_data_c);
            w_done_q.push_back(done);
            w_cyc_q.push_back(cyc);
        end
    end

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reduce an exact sum to W bits: clamp in the saturating build, wrap otherwise.
    function automatic logic [W-1:0] lim(input longint x);
`ifdef DPA_SATURATE_EN
        if (x > 64'sd2147483647) begin
            model_ovf = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (x < -64'sd2147483648) begin
            model_ovf = 1'b1;
            return 32'h8000_0000;
        end
`endif
        return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_elem(input int e);
        logic [W-1:0] acc, s12, s34, t;
        acc = '0;
        for (int b = 0; b < BEATS; b++) begin
            int i;
            i   = e * BEATS + b;
            s12 = lim(sx(pr[i][0]) + sx(pr[i][1]));
            s34 = lim(sx(pr[i][2]) + sx(pr[i][3]));
            t   = lim(sx(s12) + sx(s34));
            acc = lim(sx(acc) + sx(t));
        end
        return acc;
    endfunction

    task automatic clear_mon();
        w_addr_q.delete();
        w_data_q.delete();
        w_done_q.delete();
        w_cyc_q.delete();
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < TOTAL; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0: pr[i][j] = 32'd1;
                    1: pr[i][j] = 32'h7FFF_FFFF;
                    2: pr[i][j] = $urandom;
                    default: pr[i][j] = 32'($urandom_range(2000)) - 32'd1000;
                endcase
            end
        end
    endtask

    task automatic apply_reset();
        prod_valid = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_beats(input int first, input int count, input int gap_pct);
        for (int b = first; b < first + count; b++) begin
            int guard;
            bit ok;
            guard = 0;
            ok = 1'b0;
            while ($urandom_range(99) < gap_pct) begin
                prod_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            prod_valid = 1'b1;
            m1 = pr[b][0]; m2 = pr[b][1]; m3 = pr[b][2]; m4 = pr[b][3];
            while (!ok && guard < 50) begin
                @(negedge clk);
                ok = prod_ready;
                if (ok) xfer_cyc[b] = cyc;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL beat_accept beat=%0d prod_ready=0 want=1", b);
                prod_valid = 1'b0;
                return;
            end
        end
        prod_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge on which done was seen.
    task automatic wait_done(input string name, input int limit, output bit seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done_timeout got=no_done want=done within %0d cycles", name, limit);
        end
    endtask

    task automatic check_writes(input string name, input bit strict_spacing);
        total++;
        if (w_addr_q.size() != ELEMS) begin
            bad++;
            $display("FAIL %s write_count got=%0d want=%0d", name, w_addr_q.size(), ELEMS);
        end
        for (int i = 0; i < ELEMS && i < w_addr_q.size(); i++) begin
            logic [W-1:0] exp_d;
            logic [5:0]   exp_a;
            exp_d = ref_elem(i);
            exp_a = 6'(i);
            total++;
            if (w_addr_q[i] !== exp_a || w_data_q[i] !== exp_d || w_done_q[i] !== (i == ELEMS - 1)) begin
                bad++;
                $display("FAIL %s write[%0d] got addr=%0d data=%h done=%0b want addr=%0d data=%h done=%0b",
                         name, i, w_addr_q[i], w_data_q[i], w_done_q[i], exp_a, exp_d, (i == ELEMS - 1));
            end
            if (strict_spacing && i > 0) begin
                total++;
                if (w_cyc_q[i] - w_cyc_q[i-1] != BEATS) begin
                    bad++;
                    $display("FAIL %s spacing[%0d] got=%0d want=%0d", name, i, w_cyc_q[i] - w_cyc_q[i-1], BEATS);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({prod_ready, wr_en, wr_address_c, wr_data_c, busy, done, protocol_err, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {prod_ready, wr_en, wr_address_c, wr_data_c, busy, done, protocol_err, overflow});
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        fill(0);
        clear_mon();
        do_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_busy_rise got=%0b want=1", busy);
        end
        send_beats(0, TOTAL, 0);
        wait_done("b2b", 50, seen);
        if (seen) begin
            total++;
            if (wr_en !== 1'b1 || wr_address_c !== 6'd63 || wr_data_c !== 32'd8 || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_final_write got wr_en=%0b addr=%0d data=%0d busy=%0b want 1 63 8 1",
                         wr_en, wr_address_c, wr_data_c, busy);
            end
            // start coincident with done must be ignored
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b_busy_fall got=%0b want=0", busy);
            end
        end
        @(negedge clk);
        check_writes("b2b", 1'b1);
        total++;
        if (protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_protocol_err got=%0b want=0", protocol_err);
        end
    endtask

    task automatic test_cancel_latency();
        bit seen;
        fill(3);
        pr[0][0] = 32'd1; pr[0][1] = 32'd2; pr[0][2] = 32'd3; pr[0][3] = 32'd4;
        pr[1][0] = -32'sd10; pr[1][1] = '0; pr[1][2] = '0; pr[1][3] = '0;
        clear_mon();
        do_start();
        send_beats(0, TOTAL, 0);
        wait_done("cancel", 50, seen);
        @(negedge clk);
        total++;
        if (w_data_q.size() == 0 || w_data_q[0] !== 32'd0) begin
            bad++;
            $display("FAIL cancel_first_data got=%h want=0", (w_data_q.size() > 0) ? w_data_q[0] : 32'hx);
        end
        total++;
        if (w_cyc_q.size() == 0 || w_cyc_q[0] - xfer_cyc[1] != 3) begin
            bad++;
            $display("FAIL cancel_latency got=%0d want=3", (w_cyc_q.size() > 0) ? w_cyc_q[0] - xfer_cyc[1] : -1);
        end
        check_writes("cancel", 1'b1);
    endtask

    task automatic test_random_gaps();
        bit seen;
        fill(2);
        clear_mon();
        do_start();
        send_beats(0, TOTAL / 2, 30);
        do_start();
        total++;
        if (busy !== 1'b1 || protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL gaps_start_while_busy got busy=%0b perr=%0b want 1 0", busy, protocol_err);
        end
        send_beats(TOTAL / 2, TOTAL / 2, 30);
        wait_done("gaps", 200, seen);
        @(negedge clk);
        check_writes("gaps", 1'b0);
    endtask

    task automatic test_protocol_err();
        clear_mon();
        @(posedge clk);
        #1 prod_valid = 1'b1;
        m1 = 32'd5; m2 = 32'd5; m3 = 32'd5; m4 = 32'd5;
        repeat (3) @(posedge clk);
        #1 prod_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (w_addr_q.size() != 0 || protocol_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid got writes=%0d perr=%0b busy=%0b want 0 1 0",
                     w_addr_q.size(), protocol_err, busy);
        end
        do_start();
        total++;
        if (protocol_err !== 1'b0) begin
            bad++;
            $display("FAIL perr_clear got=%0b want=0", protocol_err);
        end
        apply_reset();
    endtask

    task automatic test_reset_midrun();
        bit seen;
        fill(2);
        do_start();
        send_beats(0, 20, 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({prod_ready, wr_en, wr_address_c, wr_data_c, busy, done, protocol_err, overflow} !== '0) begin
            bad++;
            $display("FAIL midrun_async_reset got=%h want=0",
                     {prod_ready, wr_en, wr_address_c, wr_data_c, busy, done, protocol_err, overflow});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        fill(3);
        do_start();
        send_beats(0, TOTAL, 10);
        wait_done("midrun", 100, seen);
        @(negedge clk);
        total++;
        if (w_addr_q.size() == 0 || w_addr_q[0] !== 6'd0 || w_data_q[0] !== ref_elem(0)) begin
            bad++;
            $display("FAIL midrun_first_write got addr=%0d data=%h want addr=0 data=%h",
                     (w_addr_q.size() > 0) ? w_addr_q[0] : 6'hx,
                     (w_data_q.size() > 0) ? w_data_q[0] : 32'hx, ref_elem(0));
        end
        check_writes("midrun", 1'b0);
    endtask

    task automatic test_saturation();
        bit seen;
        logic [W-1:0] exp_d;
        logic         exp_ovf;
`ifdef DPA_SATURATE_EN
        exp_d = 32'h7FFF_FFFF;
        exp_ovf = 1'b1;
`else
        exp_d = 32'hFFFF_FFF8;
        exp_ovf = 1'b0;
`endif
        fill(1);
        clear_mon();
        do_start();
        send_beats(0, TOTAL, 0);
        wait_done("sat", 50, seen);
        @(negedge clk);
        total++;
        if (w_data_q.size() == 0 || w_data_q[0] !== exp_d) begin
            bad++;
            $display("FAIL sat_data got=%h want=%h", (w_data_q.size() > 0) ? w_data_q[0] : 32'hx, exp_d);
        end
        total++;
        if (overflow !== exp_ovf) begin
            bad++;
            $display("FAIL sat_overflow got=%0b want=%0b", overflow, exp_ovf);
        end
        model_ovf = 1'b0;
        check_writes("sat", 1'b1);
        total++;
        if (overflow !== model_ovf) begin
            bad++;
            $display("FAIL sat_overflow_model got=%0b want=%0b", overflow, model_ovf);
        end
    endtask

    initial begin
        model_ovf = 1'b0;
        test_reset();
        test_back_to_back();
        test_cancel_latency();
        test_random_gaps();
        test_protocol_err();
        test_reset_midrun();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
